// File: rtl/br_credit_sender_rv2cv_if.sv
// Handshake bundle for the credit sender: the upstream ready-valid push side and
// the downstream credit-valid pop side, including both reset indications.
interface br_credit_sender_rv2cv_if #(
  parameter int Width = 1
);
  logic             push_valid;
  logic             push_ready;
  logic [Width-1:0] push_data;
  logic             pop_valid;
  logic [Width-1:0] pop_data;
  logic             pop_credit;
  logic             pop_sender_in_reset;
  logic             pop_receiver_in_reset;

  // The sender block sits on the slave side of this bundle.
  modport slave (
    input  push_valid, push_data, pop_credit, pop_receiver_in_reset,
    output push_ready, pop_valid, pop_data, pop_sender_in_reset
  );

  modport master (
    output push_valid, push_data, pop_credit, pop_receiver_in_reset,
    input  push_ready, pop_valid, pop_data, pop_sender_in_reset
  );
endinterface

// File: rtl/br_credit_sender_rv2cv.sv
// Ready-valid to credit-valid bridge: tracks sender credits, gates push_ready on
// available (non-withheld) credit and forwards each accepted beat as a pop pulse.
module br_credit_sender_rv2cv #(
  parameter int Width              = 1,
  parameter int MaxCredit          = 2,
  parameter int RegisterPopOutputs = 0,
  localparam int CreditWidth       = $clog2(MaxCredit + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  br_credit_sender_rv2cv_if.slave bus,
  input  logic [CreditWidth-1:0] credit_initial,
  input  logic [CreditWidth-1:0] credit_withhold,
  output logic [CreditWidth-1:0] credit_count,
  output logic [CreditWidth-1:0] credit_available
);

  localparam logic [CreditWidth-1:0] MaxCreditC = CreditWidth'(MaxCredit);

  logic                   r_init_pending;
  logic                   r_sender_in_reset;
  logic [CreditWidth-1:0] r_credit_count;

  logic                   w_init_active;
  logic                   w_bypass_ok;
  logic                   w_push_ready;
  logic                   w_handshake;
  logic                   w_overflow;
  logic                   w_underflow;
  logic [CreditWidth-1:0] w_credit_available;
  logic [CreditWidth-1:0] w_credit_count_next;

  assign w_init_active      = r_init_pending | bus.pop_receiver_in_reset;
  assign w_credit_available = (r_credit_count > credit_withhold) ?
                              (r_credit_count - credit_withhold) : '0;
  // A credit arriving this cycle can be spent at once if it would not be withheld.
  assign w_bypass_ok  = bus.pop_credit && (r_credit_count < MaxCreditC) &&
                        (r_credit_count >= credit_withhold);
  assign w_push_ready = !w_init_active && ((w_credit_available != '0) || w_bypass_ok);
  assign w_handshake  = bus.push_valid & w_push_ready;

  assign w_overflow  = !w_init_active && bus.pop_credit && !w_handshake &&
                       (r_credit_count == MaxCreditC);
  assign w_underflow = !w_init_active && w_handshake && !bus.pop_credit &&
                       (r_credit_count == '0);

  always_comb begin
    w_credit_count_next = r_credit_count;
    if (w_init_active) begin
      w_credit_count_next = credit_initial;
    end else begin
      unique case ({bus.pop_credit, w_handshake})
        2'b10: if (r_credit_count < MaxCreditC)
                 w_credit_count_next = r_credit_count + CreditWidth'(1);
        2'b01: if (r_credit_count != '0)
                 w_credit_count_next = r_credit_count - CreditWidth'(1);
        default: w_credit_count_next = r_credit_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_pending    <= 1'b1;
      r_sender_in_reset <= 1'b1;
      r_credit_count    <= '0;
    end else begin
      r_init_pending    <= r_init_pending & bus.pop_receiver_in_reset;
      r_sender_in_reset <= 1'b0;
      r_credit_count    <= w_credit_count_next;
    end
  end

  generate
    if (RegisterPopOutputs != 0) begin : g_reg_pop
      logic             r_pop_valid;
      logic [Width-1:0] r_pop_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pop_valid <= 1'b0;
          r_pop_data  <= '0;
        end else begin
          r_pop_valid <= w_handshake & !w_init_active;
          if (w_handshake) r_pop_data <= bus.push_data;
        end
      end

      assign bus.pop_valid = r_pop_valid;
      assign bus.pop_data  = r_pop_data;
    end else begin : g_comb_pop
      assign bus.pop_valid = w_handshake;
      assign bus.pop_data  = bus.push_data;
    end
  endgenerate

  assign bus.push_ready          = w_push_ready;
  assign bus.pop_sender_in_reset = r_sender_in_reset;
  assign credit_count            = r_credit_count;
  assign credit_available        = w_credit_available;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !w_overflow);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !w_underflow);

endmodule

// File: tb/tb_br_credit_sender_rv2cv.sv
// Drives a combinational-pop and a registered-pop sender with identical stimulus
// and checks both against a credit-accounting reference model every cycle.
module tb_br_credit_sender_rv2cv;
  localparam int W   = 8;
  localparam int MAX = 7;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pv, credit, rir;
  logic [W-1:0]  pd;
  logic [CW-1:0] ci, wh;
  logic [CW-1:0] count0, avail0, count1, avail1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, valid for the cycle currently being observed.
  int       m_count = 0;
  bit       m_init  = 1'b1;
  bit       m_sir   = 1'b1;
  bit       m_rv    = 1'b0;
  int       m_rd    = 0;

  br_credit_sender_rv2cv_if #(.Width(W)) if0 ();
  br_credit_sender_rv2cv_if #(.Width(W)) if1 ();

  assign if0.push_valid = pv;            assign if1.push_valid = pv;
  assign if0.push_data  = pd;            assign if1.push_data  = pd;
  assign if0.pop_credit = credit;        assign if1.pop_credit = credit;
  assign if0.pop_receiver_in_reset = rir; assign if1.pop_receiver_in_reset = rir;

  br_credit_sender_rv2cv #(.Width(W), .MaxCredit(MAX), .RegisterPopOutputs(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .credit_initial(ci),
    .credit_withhold(wh), .credit_count(count0), .credit_available(avail0));

  br_credit_sender_rv2cv #(.Width(W), .MaxCredit(MAX), .RegisterPopOutputs(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .credit_initial(ci),
    .credit_withhold(wh), .credit_count(count1), .credit_available(avail1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: expectations derived from credit arithmetic, then advance model.
  initial begin
    int  avail;
    bit  active, ready, hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_count0", count0, 0);           chk("rst_count1", count1, 0);
        chk("rst_ready0", if0.push_ready, 0);   chk("rst_ready1", if1.push_ready, 0);
        chk("rst_pv0", if0.pop_valid, 0);       chk("rst_pv1", if1.pop_valid, 0);
        chk("rst_pd1", if1.pop_data, 0);
        chk("rst_sir0", if0.pop_sender_in_reset, 1);
        chk("rst_sir1", if1.pop_sender_in_reset, 1);
        m_count = 0; m_init = 1'b1; m_sir = 1'b1; m_rv = 1'b0; m_rd = 0;
      end else begin
        avail  = (m_count > int'(wh)) ? m_count - int'(wh) : 0;
        active = m_init || rir;
        ready  = !active && (avail > 0 ||
                 (credit && m_count < MAX && m_count + 1 - int'(wh) > 0));
        hs     = pv && ready;
        chk("count0", count0, m_count);          chk("count1", count1, m_count);
        chk("avail0", avail0, avail);            chk("avail1", avail1, avail);
        chk("ready0", if0.push_ready, ready);    chk("ready1", if1.push_ready, ready);
        chk("pv0", if0.pop_valid, hs);           chk("pd0", if0.pop_data, pd);
        chk("pv1", if1.pop_valid, m_rv);         chk("pd1", if1.pop_data, m_rd);
        chk("sir0", if0.pop_sender_in_reset, m_sir);
        chk("sir1", if1.pop_sender_in_reset, m_sir);
        m_count = active ? int'(ci) : m_count + (credit ? 1 : 0) - (hs ? 1 : 0);
        m_rv    = hs;
        if (hs) m_rd = int'(pd);
        m_init  = m_init && rir;
        m_sir   = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; pv = 1'b0; credit = 1'b0; rir = 1'b0; pd = '0; ci = 3'd2; wh = 3'd0;

    // Init: first edge after release loads credit_initial.
    repeat (2) step();
    @(negedge clk);
    chk("lit_rst_count", count0, 0); chk("lit_rst_sir", if0.pop_sender_in_reset, 1);
    step(); rst_n = 1'b1;
    step(); pv = 1'b1; pd = 8'h11;
    @(negedge clk);
    chk("lit_init_count", count0, 2); chk("lit_init_ready", if0.push_ready, 1);
    chk("lit_init_sir", if0.pop_sender_in_reset, 0); chk("lit_ex_pv0_a", if0.pop_valid, 1);

    // Exhaust: three back-to-back pushes against two credits.
    step(); pd = 8'h22;
    @(negedge clk);
    chk("lit_ex_pv0_b", if0.pop_valid, 1); chk("lit_ex_pv1_a", if1.pop_valid, 1);
    chk("lit_ex_pd1_a", if1.pop_data, 8'h11);
    step(); pd = 8'h33;
    @(negedge clk);
    chk("lit_ex_count", count0, 0); chk("lit_ex_ready", if0.push_ready, 0);
    chk("lit_ex_pv0_c", if0.pop_valid, 0);
    step(); pv = 1'b0;

    // Bypass: credit and push in the same cycle at zero count.
    step(); pv = 1'b1; pd = 8'h5A; credit = 1'b1;
    @(negedge clk);
    chk("lit_bp_ready", if0.push_ready, 1); chk("lit_bp_pv0", if0.pop_valid, 1);
    step(); pv = 1'b0; credit = 1'b0;
    @(negedge clk);
    chk("lit_bp_count", count0, 0);

    // Withhold: build count to 3, hide all of it, then release two.
    step(); credit = 1'b1;
    repeat (3) step();
    credit = 1'b0; wh = 3'd3;
    @(negedge clk);
    chk("lit_wh_count", count0, 3); chk("lit_wh_avail0", avail0, 0);
    chk("lit_wh_ready0", if0.push_ready, 0);
    step(); wh = 3'd1;
    @(negedge clk);
    chk("lit_wh_avail1", avail0, 2); chk("lit_wh_ready1", if0.push_ready, 1);

    // Registered pop: one push of 0xA5.
    step(); wh = 3'd0; pv = 1'b1; pd = 8'hA5;
    @(negedge clk);
    chk("lit_reg_pv_pre", if1.pop_valid, 0);
    step(); pv = 1'b0;
    @(negedge clk);
    chk("lit_reg_pv", if1.pop_valid, 1); chk("lit_reg_pd", if1.pop_data, 8'hA5);
    step();
    @(negedge clk);
    chk("lit_reg_pv_post", if1.pop_valid, 0);

    // Receiver reset: count 1, two-cycle pulse with credit_initial=4.
    step(); pv = 1'b1; pd = 8'h00;
    step(); pv = 1'b0;
    @(negedge clk);
    chk("lit_rr_count_pre", count0, 1);
    step(); rir = 1'b1; ci = 3'd4; pv = 1'b1; credit = 1'b1;
    @(negedge clk);
    chk("lit_rr_ready_a", if0.push_ready, 0); chk("lit_rr_pv0_a", if0.pop_valid, 0);
    step();
    @(negedge clk);
    chk("lit_rr_pv0_b", if0.pop_valid, 0); chk("lit_rr_pv1_b", if1.pop_valid, 0);
    step(); rir = 1'b0; pv = 1'b0; credit = 1'b0;
    @(negedge clk);
    chk("lit_rr_count", count0, 4); chk("lit_rr_pv1_c", if1.pop_valid, 0);

    // Randomized phase, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n  = ($urandom_range(0, 299) != 0);
      rir    = ($urandom_range(0, 49) == 0);
      pv     = 1'($urandom_range(0, 1));
      pd     = 8'($urandom);
      credit = (m_count < MAX) && ($urandom_range(0, 1) == 1);
      ci     = CW'($urandom_range(0, MAX));
      if ($urandom_range(0, 19) == 0) wh = CW'($urandom_range(0, 3));
    end
    step(); rst_n = 1'b1; rir = 1'b0; pv = 1'b0; credit = 1'b0;
    @(negedge clk);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
